// File: rtl/commit_perf_tracker.sv
// Per-instruction stage-cycle collector for the multi-cycle core; emits one commit record per retire.
// Optional retire watchdog (hang output) is built only when COMMIT_WATCHDOG_EN is defined.
module commit_perf_tracker #(
   parameter int CNT_W      = 64,
   parameter int WDT_CYCLES = 100000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ifuOutFire,
   input  logic             iduOutFire,
   input  logic             exuOutFire,
   input  logic             lsuOutFire,
   input  logic             wbuOutFire,
   input  logic             icacheResultValid,
   input  logic             icacheResultHit,
   input  logic             icacheRefillBusy,
   output logic             commitValid,
   output logic             icacheNeed,
   output logic             icacheHit,
   output logic [CNT_W-1:0] icacheCostCycle,
   output logic [CNT_W-1:0] icacheMissCost,
   output logic [CNT_W-1:0] iduCostCycle,
   output logic [CNT_W-1:0] exuCostCycle,
   output logic [CNT_W-1:0] lsuCostCycle,
   output logic [CNT_W-1:0] wbuCostCycle,
   output logic [CNT_W-1:0] instRet,
   output logic [CNT_W-1:0] totalCycles,
   output logic             protoErr,
   output logic             hang
);

   typedef enum logic [2:0] {ST_IF, ST_ID, ST_EX, ST_LS, ST_WB} state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic [CNT_W-1:0] stage_cnt;
   logic [CNT_W-1:0] miss_cnt;
   logic [CNT_W-1:0] cost_now;
   logic [CNT_W-1:0] icache_cost_w;
   logic [CNT_W-1:0] miss_cost_w;
   logic [CNT_W-1:0] idu_cost_w;
   logic [CNT_W-1:0] exu_cost_w;
   logic [CNT_W-1:0] lsu_cost_w;
   logic             need_w;
   logic             hit_w;
   logic [4:0]       fires;
   logic [4:0]       own;
   logic             multi;
   logic             stray;
   logic             proto_now;
   logic             advance;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + ONE;
   endfunction

   // Any protocol violation in a cycle freezes the FSM, even if the owning fire is also present.
   always_comb begin
      fires = {wbuOutFire, lsuOutFire, exuOutFire, iduOutFire, ifuOutFire};
      own   = '0;
      case (state)
         ST_IF:   own = 5'b00001;
         ST_ID:   own = 5'b00010;
         ST_EX:   own = 5'b00100;
         ST_LS:   own = 5'b01000;
         ST_WB:   own = 5'b10000;
         default: own = '0;
      endcase
      multi     = (fires & (fires - 5'd1)) != 5'd0;
      stray     = (fires & ~own) != 5'd0;
      proto_now = multi | stray | (icacheResultValid & (state != ST_IF));
      advance   = ((fires & own) != 5'd0) & ~proto_now;
      cost_now  = sat_inc(stage_cnt);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= ST_IF;
         stage_cnt       <= '0;
         miss_cnt        <= '0;
         icache_cost_w   <= '0;
         miss_cost_w     <= '0;
         idu_cost_w      <= '0;
         exu_cost_w      <= '0;
         lsu_cost_w      <= '0;
         need_w          <= 1'b0;
         hit_w           <= 1'b0;
         commitValid     <= 1'b0;
         icacheNeed      <= 1'b0;
         icacheHit       <= 1'b0;
         icacheCostCycle <= '0;
         icacheMissCost  <= '0;
         iduCostCycle    <= '0;
         exuCostCycle    <= '0;
         lsuCostCycle    <= '0;
         wbuCostCycle    <= '0;
         instRet         <= '0;
         totalCycles     <= '0;
         protoErr        <= 1'b0;
      end else begin
         commitValid <= 1'b0;
         totalCycles <= sat_inc(totalCycles);
         if (proto_now) protoErr <= 1'b1;
         if (state == ST_IF && icacheResultValid && !need_w) begin
            need_w <= 1'b1;
            hit_w  <= icacheResultHit;
         end
         if (state == ST_IF && icacheRefillBusy) miss_cnt <= sat_inc(miss_cnt);
         if (advance) begin
            stage_cnt <= '0;
            case (state)
               ST_IF: begin
                  icache_cost_w <= cost_now;
                  miss_cost_w   <= icacheRefillBusy ? sat_inc(miss_cnt) : miss_cnt;
                  state         <= ST_ID;
               end
               ST_ID: begin
                  idu_cost_w <= cost_now;
                  state      <= ST_EX;
               end
               ST_EX: begin
                  exu_cost_w <= cost_now;
                  state      <= ST_LS;
               end
               ST_LS: begin
                  lsu_cost_w <= cost_now;
                  state      <= ST_WB;
               end
               ST_WB: begin
                  // Whole record lands in the output registers at once, visible with the strobe.
                  commitValid     <= 1'b1;
                  icacheNeed      <= need_w;
                  icacheHit       <= hit_w;
                  icacheCostCycle <= icache_cost_w;
                  icacheMissCost  <= miss_cost_w;
                  iduCostCycle    <= idu_cost_w;
                  exuCostCycle    <= exu_cost_w;
                  lsuCostCycle    <= lsu_cost_w;
                  wbuCostCycle    <= cost_now;
                  instRet         <= sat_inc(instRet);
                  miss_cnt        <= '0;
                  need_w          <= 1'b0;
                  hit_w           <= 1'b0;
                  state           <= ST_IF;
               end
               default: state <= ST_IF;
            endcase
         end else begin
            stage_cnt <= sat_inc(stage_cnt);
         end
      end
   end

`ifdef COMMIT_WATCHDOG_EN
   localparam int               WDT_W   = $clog2(WDT_CYCLES + 1);
   localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES);

   logic [WDT_W-1:0] wdt_cnt;
   logic [WDT_W-1:0] wdt_next;

   always_comb begin
      if (commitValid)             wdt_next = '0;
      else if (wdt_cnt == WDT_MAX) wdt_next = wdt_cnt;
      else                         wdt_next = wdt_cnt + WDT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wdt_cnt <= '0;
         hang    <= 1'b0;
      end else begin
         wdt_cnt <= wdt_next;
         if (wdt_next == WDT_MAX) hang <= 1'b1;
      end
   end
`else
   assign hang = 1'b0;
`endif

endmodule

// File: tb/tb_commit_perf_tracker.sv
// Directed self-checking bench for commit_perf_tracker: hit/miss paths, back-to-back retire,
// protocol errors, reset mid-instruction and the hang output (watchdog when COMMIT_WATCHDOG_EN).
module tb_commit_perf_tracker;

   localparam int W = 64;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         ifuOutFire = 1'b0;
   logic         iduOutFire = 1'b0;
   logic         exuOutFire = 1'b0;
   logic         lsuOutFire = 1'b0;
   logic         wbuOutFire = 1'b0;
   logic         icacheResultValid = 1'b0;
   logic         icacheResultHit = 1'b0;
   logic         icacheRefillBusy = 1'b0;
   logic         commitValid;
   logic         icacheNeed;
   logic         icacheHit;
   logic [W-1:0] icacheCostCycle;
   logic [W-1:0] icacheMissCost;
   logic [W-1:0] iduCostCycle;
   logic [W-1:0] exuCostCycle;
   logic [W-1:0] lsuCostCycle;
   logic [W-1:0] wbuCostCycle;
   logic [W-1:0] instRet;
   logic [W-1:0] totalCycles;
   logic         protoErr;
   logic         hang;

   int chk = 0;
   int pass = 0;

   commit_perf_tracker #(.CNT_W(W), .WDT_CYCLES(50)) dut (
      .clock(clock), .reset(reset),
      .ifuOutFire(ifuOutFire), .iduOutFire(iduOutFire), .exuOutFire(exuOutFire),
      .lsuOutFire(lsuOutFire), .wbuOutFire(wbuOutFire),
      .icacheResultValid(icacheResultValid), .icacheResultHit(icacheResultHit),
      .icacheRefillBusy(icacheRefillBusy),
      .commitValid(commitValid), .icacheNeed(icacheNeed), .icacheHit(icacheHit),
      .icacheCostCycle(icacheCostCycle), .icacheMissCost(icacheMissCost),
      .iduCostCycle(iduCostCycle), .exuCostCycle(exuCostCycle),
      .lsuCostCycle(lsuCostCycle), .wbuCostCycle(wbuCostCycle),
      .instRet(instRet), .totalCycles(totalCycles), .protoErr(protoErr), .hang(hang)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_fire(input int idx, input logic v);
      case (idx)
         0: ifuOutFire = v;
         1: iduOutFire = v;
         2: exuOutFire = v;
         3: lsuOutFire = v;
         default: wbuOutFire = v;
      endcase
   endtask

   task automatic pulse_fire(input int idx, input int idle);
      repeat (idle) step();
      set_fire(idx, 1'b1);
      step();
      set_fire(idx, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      chk++; if (commitValid !== 1'b0) $display("FAIL rst_commit: got %0d exp 0", commitValid); else pass++;
      chk++; if (instRet !== 64'd0) $display("FAIL rst_instret: got %0d exp 0", instRet); else pass++;
      chk++; if (totalCycles !== 64'd0) $display("FAIL rst_total: got %0d exp 0", totalCycles); else pass++;
      chk++; if (protoErr !== 1'b0) $display("FAIL rst_proto: got %0d exp 0", protoErr); else pass++;
      chk++; if (icacheCostCycle !== 64'd0) $display("FAIL rst_icost: got %0d exp 0", icacheCostCycle); else pass++;
      chk++; if (wbuCostCycle !== 64'd0) $display("FAIL rst_wcost: got %0d exp 0", wbuCostCycle); else pass++;
      chk++; if (icacheNeed !== 1'b0) $display("FAIL rst_need: got %0d exp 0", icacheNeed); else pass++;
      chk++; if (hang !== 1'b0) $display("FAIL rst_hang: got %0d exp 0", hang); else pass++;
      reset = 1'b0;
      repeat (3) step();
      chk++; if (totalCycles !== 64'd3) $display("FAIL rst_total_run: got %0d exp 3", totalCycles); else pass++;
      chk++; if (commitValid !== 1'b0) $display("FAIL rst_idle_commit: got %0d exp 0", commitValid); else pass++;
   endtask

   task automatic test_hit_path();
      do_reset();
      step();
      icacheResultValid = 1'b1; icacheResultHit = 1'b1;
      step();
      icacheResultValid = 1'b0; icacheResultHit = 1'b0;
      pulse_fire(0, 0);
      pulse_fire(1, 1);
      pulse_fire(2, 1);
      pulse_fire(3, 1);
      pulse_fire(4, 1);
      chk++; if (commitValid !== 1'b1) $display("FAIL hit_commit: got %0d exp 1", commitValid); else pass++;
      chk++; if (icacheCostCycle !== 64'd3) $display("FAIL hit_icost: got %0d exp 3", icacheCostCycle); else pass++;
      chk++; if (icacheMissCost !== 64'd0) $display("FAIL hit_miss: got %0d exp 0", icacheMissCost); else pass++;
      chk++; if (icacheNeed !== 1'b1) $display("FAIL hit_need: got %0d exp 1", icacheNeed); else pass++;
      chk++; if (icacheHit !== 1'b1) $display("FAIL hit_hit: got %0d exp 1", icacheHit); else pass++;
      chk++; if (iduCostCycle !== 64'd2) $display("FAIL hit_idu: got %0d exp 2", iduCostCycle); else pass++;
      chk++; if (exuCostCycle !== 64'd2) $display("FAIL hit_exu: got %0d exp 2", exuCostCycle); else pass++;
      chk++; if (lsuCostCycle !== 64'd2) $display("FAIL hit_lsu: got %0d exp 2", lsuCostCycle); else pass++;
      chk++; if (wbuCostCycle !== 64'd2) $display("FAIL hit_wbu: got %0d exp 2", wbuCostCycle); else pass++;
      chk++; if (instRet !== 64'd1) $display("FAIL hit_instret: got %0d exp 1", instRet); else pass++;
      chk++; if (totalCycles !== 64'd11) $display("FAIL hit_total: got %0d exp 11", totalCycles); else pass++;
      chk++; if (protoErr !== 1'b0) $display("FAIL hit_proto: got %0d exp 0", protoErr); else pass++;
      step();
      chk++; if (commitValid !== 1'b0) $display("FAIL hit_strobe_len: got %0d exp 0", commitValid); else pass++;
      chk++; if (icacheCostCycle !== 64'd3) $display("FAIL hit_hold: got %0d exp 3", icacheCostCycle); else pass++;
   endtask

   task automatic test_miss_path();
      do_reset();
      icacheResultValid = 1'b1; icacheResultHit = 1'b0;
      step();
      icacheResultValid = 1'b0;
      icacheRefillBusy = 1'b1;
      repeat (10) step();
      icacheRefillBusy = 1'b0;
      step();
      pulse_fire(0, 0);
      pulse_fire(1, 0);
      pulse_fire(2, 0);
      pulse_fire(3, 0);
      pulse_fire(4, 0);
      chk++; if (commitValid !== 1'b1) $display("FAIL miss_commit: got %0d exp 1", commitValid); else pass++;
      chk++; if (icacheCostCycle !== 64'd13) $display("FAIL miss_icost: got %0d exp 13", icacheCostCycle); else pass++;
      chk++; if (icacheMissCost !== 64'd10) $display("FAIL miss_miss: got %0d exp 10", icacheMissCost); else pass++;
      chk++; if (icacheNeed !== 1'b1) $display("FAIL miss_need: got %0d exp 1", icacheNeed); else pass++;
      chk++; if (icacheHit !== 1'b0) $display("FAIL miss_hit: got %0d exp 0", icacheHit); else pass++;
      chk++; if (iduCostCycle !== 64'd1) $display("FAIL miss_idu: got %0d exp 1", iduCostCycle); else pass++;
      chk++; if (instRet !== 64'd1) $display("FAIL miss_instret: got %0d exp 1", instRet); else pass++;
   endtask

   // Continues directly from the miss-path commit cycle, without reset.
   task automatic test_back_to_back();
      pulse_fire(0, 0);
      chk++; if (commitValid !== 1'b0) $display("FAIL b2b_no_commit: got %0d exp 0", commitValid); else pass++;
      pulse_fire(1, 0);
      pulse_fire(2, 0);
      pulse_fire(3, 0);
      chk++; if (icacheCostCycle !== 64'd13) $display("FAIL b2b_hold_icost: got %0d exp 13", icacheCostCycle); else pass++;
      chk++; if (icacheMissCost !== 64'd10) $display("FAIL b2b_hold_miss: got %0d exp 10", icacheMissCost); else pass++;
      pulse_fire(4, 0);
      chk++; if (commitValid !== 1'b1) $display("FAIL b2b_commit1: got %0d exp 1", commitValid); else pass++;
      chk++; if (icacheCostCycle !== 64'd1) $display("FAIL b2b1_icost: got %0d exp 1", icacheCostCycle); else pass++;
      chk++; if (icacheMissCost !== 64'd0) $display("FAIL b2b1_miss: got %0d exp 0", icacheMissCost); else pass++;
      chk++; if (icacheNeed !== 1'b0) $display("FAIL b2b1_need: got %0d exp 0", icacheNeed); else pass++;
      chk++; if (lsuCostCycle !== 64'd1) $display("FAIL b2b1_lsu: got %0d exp 1", lsuCostCycle); else pass++;
      chk++; if (wbuCostCycle !== 64'd1) $display("FAIL b2b1_wbu: got %0d exp 1", wbuCostCycle); else pass++;
      chk++; if (instRet !== 64'd2) $display("FAIL b2b1_instret: got %0d exp 2", instRet); else pass++;
      for (int s = 0; s < 5; s++) begin
         set_fire(s, 1'b1);
         if (s == 0) begin
            icacheResultValid = 1'b1; icacheResultHit = 1'b1;
         end
         step();
         set_fire(s, 1'b0);
         icacheResultValid = 1'b0; icacheResultHit = 1'b0;
         if (s < 4) begin
            chk++; if (commitValid !== 1'b0) $display("FAIL b2b_gap_commit s%0d: got %0d exp 0", s, commitValid); else pass++;
            chk++; if (instRet !== 64'd2) $display("FAIL b2b_gap_instret s%0d: got %0d exp 2", s, instRet); else pass++;
            chk++; if (icacheNeed !== 1'b0) $display("FAIL b2b_gap_need s%0d: got %0d exp 0", s, icacheNeed); else pass++;
         end
      end
      chk++; if (commitValid !== 1'b1) $display("FAIL b2b_commit2: got %0d exp 1", commitValid); else pass++;
      chk++; if (icacheCostCycle !== 64'd1) $display("FAIL b2b2_icost: got %0d exp 1", icacheCostCycle); else pass++;
      chk++; if (icacheNeed !== 1'b1) $display("FAIL b2b2_need: got %0d exp 1", icacheNeed); else pass++;
      chk++; if (icacheHit !== 1'b1) $display("FAIL b2b2_hit: got %0d exp 1", icacheHit); else pass++;
      chk++; if (exuCostCycle !== 64'd1) $display("FAIL b2b2_exu: got %0d exp 1", exuCostCycle); else pass++;
      chk++; if (instRet !== 64'd3) $display("FAIL b2b2_instret: got %0d exp 3", instRet); else pass++;
      chk++; if (protoErr !== 1'b0) $display("FAIL b2b_proto: got %0d exp 0", protoErr); else pass++;
   endtask

   task automatic test_proto_stray();
      do_reset();
      exuOutFire = 1'b1;
      step();
      exuOutFire = 1'b0;
      chk++; if (protoErr !== 1'b1) $display("FAIL stray_proto: got %0d exp 1", protoErr); else pass++;
      chk++; if (commitValid !== 1'b0) $display("FAIL stray_commit: got %0d exp 0", commitValid); else pass++;
      pulse_fire(0, 0);
      pulse_fire(1, 0);
      pulse_fire(2, 1);
      pulse_fire(3, 2);
      pulse_fire(4, 0);
      chk++; if (commitValid !== 1'b1) $display("FAIL stray_after_commit: got %0d exp 1", commitValid); else pass++;
      chk++; if (icacheCostCycle !== 64'd2) $display("FAIL stray_icost: got %0d exp 2", icacheCostCycle); else pass++;
      chk++; if (iduCostCycle !== 64'd1) $display("FAIL stray_idu: got %0d exp 1", iduCostCycle); else pass++;
      chk++; if (exuCostCycle !== 64'd2) $display("FAIL stray_exu: got %0d exp 2", exuCostCycle); else pass++;
      chk++; if (lsuCostCycle !== 64'd3) $display("FAIL stray_lsu: got %0d exp 3", lsuCostCycle); else pass++;
      chk++; if (instRet !== 64'd1) $display("FAIL stray_instret: got %0d exp 1", instRet); else pass++;
      chk++; if (protoErr !== 1'b1) $display("FAIL stray_sticky: got %0d exp 1", protoErr); else pass++;
   endtask

   task automatic test_proto_multi();
      do_reset();
      pulse_fire(0, 0);
      chk++; if (protoErr !== 1'b0) $display("FAIL multi_clean: got %0d exp 0", protoErr); else pass++;
      iduOutFire = 1'b1; exuOutFire = 1'b1;
      step();
      iduOutFire = 1'b0; exuOutFire = 1'b0;
      chk++; if (protoErr !== 1'b1) $display("FAIL multi_proto: got %0d exp 1", protoErr); else pass++;
      pulse_fire(1, 0);
      pulse_fire(2, 0);
      pulse_fire(3, 0);
      pulse_fire(4, 0);
      chk++; if (commitValid !== 1'b1) $display("FAIL multi_commit: got %0d exp 1", commitValid); else pass++;
      chk++; if (iduCostCycle !== 64'd2) $display("FAIL multi_idu: got %0d exp 2", iduCostCycle); else pass++;
      chk++; if (exuCostCycle !== 64'd1) $display("FAIL multi_exu: got %0d exp 1", exuCostCycle); else pass++;
   endtask

   task automatic test_proto_lookup();
      do_reset();
      pulse_fire(0, 0);
      icacheResultValid = 1'b1; icacheResultHit = 1'b1;
      step();
      icacheResultValid = 1'b0; icacheResultHit = 1'b0;
      chk++; if (protoErr !== 1'b1) $display("FAIL lookup_proto: got %0d exp 1", protoErr); else pass++;
      pulse_fire(1, 0);
      pulse_fire(2, 0);
      pulse_fire(3, 0);
      pulse_fire(4, 0);
      chk++; if (commitValid !== 1'b1) $display("FAIL lookup_commit: got %0d exp 1", commitValid); else pass++;
      chk++; if (icacheNeed !== 1'b0) $display("FAIL lookup_need: got %0d exp 0", icacheNeed); else pass++;
      chk++; if (icacheHit !== 1'b0) $display("FAIL lookup_hit: got %0d exp 0", icacheHit); else pass++;
      chk++; if (iduCostCycle !== 64'd2) $display("FAIL lookup_idu: got %0d exp 2", iduCostCycle); else pass++;
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      for (int s = 0; s < 5; s++) pulse_fire(s, 1);
      chk++; if (instRet !== 64'd1) $display("FAIL mid_pre_instret: got %0d exp 1", instRet); else pass++;
      pulse_fire(0, 0);
      pulse_fire(1, 0);
      step();
      reset = 1'b1;
      step();
      chk++; if (commitValid !== 1'b0) $display("FAIL mid_commit: got %0d exp 0", commitValid); else pass++;
      chk++; if (instRet !== 64'd0) $display("FAIL mid_instret: got %0d exp 0", instRet); else pass++;
      chk++; if (totalCycles !== 64'd0) $display("FAIL mid_total: got %0d exp 0", totalCycles); else pass++;
      chk++; if (icacheCostCycle !== 64'd0) $display("FAIL mid_icost: got %0d exp 0", icacheCostCycle); else pass++;
      chk++; if (wbuCostCycle !== 64'd0) $display("FAIL mid_wcost: got %0d exp 0", wbuCostCycle); else pass++;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk++; if (commitValid !== 1'b0) $display("FAIL mid_idle_commit c%0d: got %0d exp 0", i, commitValid); else pass++;
      end
      pulse_fire(0, 0);
      pulse_fire(1, 0);
      pulse_fire(2, 0);
      pulse_fire(3, 0);
      pulse_fire(4, 0);
      chk++; if (commitValid !== 1'b1) $display("FAIL mid_after_commit: got %0d exp 1", commitValid); else pass++;
      chk++; if (icacheCostCycle !== 64'd5) $display("FAIL mid_after_icost: got %0d exp 5", icacheCostCycle); else pass++;
      chk++; if (instRet !== 64'd1) $display("FAIL mid_after_instret: got %0d exp 1", instRet); else pass++;
      chk++; if (protoErr !== 1'b0) $display("FAIL mid_after_proto: got %0d exp 0", protoErr); else pass++;
   endtask

   task automatic test_watchdog();
      do_reset();
`ifdef COMMIT_WATCHDOG_EN
      repeat (49) step();
      chk++; if (hang !== 1'b0) $display("FAIL wdt_early: got %0d exp 0", hang); else pass++;
      step();
      chk++; if (hang !== 1'b1) $display("FAIL wdt_fire: got %0d exp 1", hang); else pass++;
      repeat (10) step();
      chk++; if (hang !== 1'b1) $display("FAIL wdt_sticky: got %0d exp 1", hang); else pass++;
`else
      repeat (60) step();
      chk++; if (hang !== 1'b0) $display("FAIL wdt_off: got %0d exp 0", hang); else pass++;
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_hit_path();
      test_miss_path();
      test_back_to_back();
      test_proto_stray();
      test_proto_multi();
      test_proto_lookup();
      test_reset_mid_op();
      test_watchdog();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule
